truth_table_sweeper: RTL and testbench

Parametrised, self-timed exhaustive stimulus engine and checker for small combinational lab circuits. On `start` it drives every input combination `0 … 2^N_IN-1` in ascending order. Each combination is held for a fixed dwell time. On the last dwell cycle the block samples the circuit's outputs and compares them against a supplied expected truth table. It sits beside the circuit under test in lab top-levels and replaces hand-written per-vector stimulus with a single pass/fail result, a mismatch count and the first failing vector.

---
 rtl/truth_table_sweeper_pkg.sv | 15 +
 rtl/truth_table_sweeper_if.sv | 32 +++
 rtl/truth_table_sweeper_dwell_timer.sv | 38 +++
 rtl/truth_table_sweeper.sv | 114 +++++++++++
 tb/tb_truth_table_sweeper.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  // Number of input vectors a sweep visits for a circuit with n_in inputs.
  function automatic int n_vec(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, expected-table and result bundle between a lab top-level and the sweeper.
interface truth_table_sweeper_if
  import sweep_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2
) ();

  localparam int TABLE_W = n_vec(N_IN) * N_OUT;

  logic               start;
  logic               pause;
  logic [TABLE_W-1:0] exp_table;
  logic [N_OUT-1:0]   dut_out;
  logic [N_IN-1:0]    stim;
  logic               busy;
  logic               done;
  logic               pass;
  logic [N_IN:0]      err_count;
  logic [N_IN-1:0]    first_err;

  modport master (
    output start, pause, exp_table, dut_out,
    input  stim, busy, done, pass, err_count, first_err
  );

  modport slave (
    input  start, pause, exp_table, dut_out,
    output stim, busy, done, pass, err_count, first_err
  );

endinterface

// File: rtl/truth_table_sweeper_dwell_timer.sv
// Per-vector dwell down-counter: load sets DWELL-1, en steps toward zero and stops there.
module dwell_timer #(
  parameter int DWELL = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [W-1:0] RELOAD = W'(DWELL - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: non-blocking assignments in clocked blocks keep all flops updating from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine and checker: steps every input vector, holds it DWELL cycles,
// compares the circuit outputs on the last dwell cycle and accumulates pass/fail results.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter int DWELL = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus
);

  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(n_vec(N_IN) - 1);

  sweep_state_t    state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            pass_q, pass_d;

  logic             timer_load;
  logic             timer_en;
  logic             timer_zero;
  logic [N_OUT-1:0] exp_vec;
  logic             mismatch;

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (timer_en),
    .zero (timer_zero)
  );

  assign exp_vec  = bus.exp_table[int'(stim_q) * N_OUT +: N_OUT];
  assign mismatch = (bus.dut_out != exp_vec);

  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    err_d      = err_q;
    first_d    = first_q;
    pass_d     = pass_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = RUN;
          stim_d     = '0;
          err_d      = '0;
          first_d    = '0;
          pass_d     = 1'b0;
          timer_load = 1'b1;
        end
      end

      RUN: begin
        // A paused cycle freezes everything, including the compare.
        if (!bus.pause) begin
          timer_en = 1'b1;
          if (timer_zero) begin
            if (mismatch) begin
              err_d = err_q + (N_IN+1)'(1);
              if (err_q == '0) begin
                first_d = stim_q;
              end
            end
            if (stim_q == LAST_VEC) begin
              state_d = DONE;
              pass_d  = (err_d == '0);
            end else begin
              stim_d     = stim_q + N_IN'(1);
              timer_load = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stim_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.stim      = stim_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.first_err = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a 3-in/2-out lab circuit, directed and randomized sweeps
// checked against per-vector hold times, sweep length and an error tally from the table.
module tb_truth_table_sweeper;

  localparam int N_IN  = 3;
  localparam int N_OUT = 2;
  localparam int DWELL = 10;
  localparam int NV    = 1 << N_IN;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  truth_table_sweeper #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .DWELL (DWELL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Circuit under test: {parity, majority} of the three inputs.
  function automatic logic [1:0] cut_model(input logic [2:0] v);
    return {v[2] ^ v[1] ^ v[0], (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])};
  endfunction

  assign bus.dut_out = cut_model(bus.stim);

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_tab [NV];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Build the expected table, flipping a random nonzero pattern into each marked entry.
  task automatic load_table(input logic [7:0] corrupt);
    for (int v = 0; v < NV; v++) begin
      exp_tab[v] = cut_model(3'(v)) ^ (corrupt[v] ? 2'($urandom_range(1, 3)) : 2'b00);
      bus.exp_table[v*N_OUT +: N_OUT] = exp_tab[v];
    end
  endtask

  task automatic expected_results(output int exp_err, output int exp_first);
    exp_err   = 0;
    exp_first = 0;
    for (int v = NV - 1; v >= 0; v--) begin
      if (exp_tab[v] != cut_model(3'(v))) begin
        exp_err++;
        exp_first = v;
      end
    end
  endtask

  // pause_mode: 0 none, 1 seven cycles at the start of vector 3, 2 random.
  task automatic run_sweep(input int pause_mode, input bit start_mid, input string name);
    int  hold [NV];
    int  paused [NV];
    int  busy_cycles, paused_total, seq_err, last_stim, p3, s, exp_err, exp_first, hold_bad;
    bit  finished, p;
    for (int v = 0; v < NV; v++) begin
      hold[v]   = 0;
      paused[v] = 0;
    end
    busy_cycles  = 0;
    paused_total = 0;
    seq_err      = 0;
    last_stim    = -1;
    p3           = 0;
    finished     = 1'b0;

    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({name, " busy_after_start"}, 32'(bus.busy), 1);
    check({name, " stim_after_start"}, 32'(bus.stim), 0);
    check({name, " err_cleared"}, 32'(bus.err_count), 0);
    check({name, " first_cleared"}, 32'(bus.first_err), 0);
    check({name, " done_low"}, 32'(bus.done), 0);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (!bus.busy) begin
        finished = 1'b1;
        break;
      end
      busy_cycles++;
      s = int'(bus.stim);
      hold[s]++;
      if (s != last_stim) begin
        if (s != last_stim + 1) seq_err++;
        last_stim = s;
      end
      case (pause_mode)
        1: p = (s == 3) && (p3 < 7);
        2: p = ($urandom_range(0, 3) == 0);
        default: p = 1'b0;
      endcase
      if (p) begin
        if (pause_mode == 1) p3++;
        paused[s]++;
        paused_total++;
      end
      bus.pause = p;
      bus.start = start_mid && (busy_cycles == 30);
    end
    bus.pause = 1'b0;
    bus.start = 1'b0;

    expected_results(exp_err, exp_first);
    hold_bad = 0;
    for (int v = 0; v < NV; v++) begin
      if (hold[v] != DWELL + paused[v]) hold_bad++;
    end
    check({name, " finished"}, 32'(finished), 1);
    check({name, " busy_cycles"}, busy_cycles, NV * DWELL + paused_total);
    check({name, " vector_order"}, seq_err, 0);
    check({name, " last_vector"}, last_stim, NV - 1);
    check({name, " vectors_bad_hold"}, hold_bad, 0);
    check({name, " done"}, 32'(bus.done), 1);
    check({name, " stim_held"}, 32'(bus.stim), NV - 1);
    check({name, " err_count"}, 32'(bus.err_count), exp_err);
    check({name, " first_err"}, 32'(bus.first_err), exp_first);
    check({name, " pass"}, 32'(bus.pass), (exp_err == 0) ? 1 : 0);
    @(negedge clk);
    check({name, " done_stable"}, 32'(bus.done), 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " stim"}, 32'(bus.stim), 0);
    check({name, " busy"}, 32'(bus.busy), 0);
    check({name, " done"}, 32'(bus.done), 0);
    check({name, " pass"}, 32'(bus.pass), 0);
    check({name, " err_count"}, 32'(bus.err_count), 0);
    check({name, " first_err"}, 32'(bus.first_err), 0);
  endtask

  task automatic mid_run_reset();
    bit reached;
    load_table(8'b0000_0010);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reached = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (bus.stim == 3'd4) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("midrst reached_vec4", 32'(reached), 1);
    check("midrst err_before", 32'(bus.err_count), 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst async");
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, 1'b0, "after_reset");
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    load_table(8'h00);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    check_reset_outputs("reset held");
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    run_sweep(0, 1'b0, "clean");
    load_table(8'b0110_0000);
    run_sweep(0, 1'b0, "faults");
    load_table(8'h00);
    run_sweep(0, 1'b0, "restart");
    run_sweep(1, 1'b0, "pause7");
    run_sweep(0, 1'b1, "start_in_run");
    mid_run_reset();

    for (int i = 0; i < 6; i++) begin
      load_table(8'($urandom));
      run_sweep(2, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
